// File: rtl/video_timing_pkg.sv
// Shared constants and types for the 720p raster timing generator.
// Defaults are CEA-861 1280x720@60 at a 74.25 MHz pixel clock.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_SETTLE   = 1024;

  localparam int COORD_W   = 12;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN
  } sup_state_e;

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing bundle from the raster generator to the TMDS encoder.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   de;
  coord_t x;
  coord_t y;
  logic   frame_start;
  logic   line_start;
  logic   running;

  modport master (
    output hsync, vsync, de, x, y, frame_start, line_start, running
  );

  modport slave (
    input hsync, vsync, de, x, y, frame_start, line_start, running
  );

endinterface

// File: rtl/video_timing_gen_lock_supervisor.sv
// Synchronises the PLL lock flag and only enables the raster once lock
// has been continuously high for SETTLE pixel clocks.
module lock_supervisor
  import video_timing_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_lock,
  output logic run_en
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  logic             lock_meta_q;
  logic             lock_s_q;
  sup_state_e       state_q, state_d;
  logic [CNT_W-1:0] settle_q, settle_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_WAIT_LOCK;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Any drop of the synchronised lock restarts the whole settle window.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (!lock_s_q) begin
      state_d  = ST_WAIT_LOCK;
      settle_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
        ST_SETTLE: begin
          if (settle_q == CNT_LAST) begin
            state_d = ST_RUN;
          end else begin
            settle_d = settle_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d  = ST_WAIT_LOCK;
          settle_d = '0;
        end
      endcase
    end
  end

  // Gating with lock_s cuts the raster one cycle before the state register follows.
  always_comb begin
    run_en = (state_q == ST_RUN) && lock_s_q;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters plus a registered decode of sync,
// data enable and pixel coordinates, gated by the lock supervisor.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int SETTLE   = DEF_SETTLE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_lock,
  video_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_totals
    $error("video_timing_gen: raster totals exceed the 12-bit coordinate range");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("video_timing_gen: SETTLE must be at least 1");
  end

  logic   run_en;
  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   de_q, de_d;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   frame_start_q, frame_start_d;
  logic   line_start_q, line_start_d;

  lock_supervisor #(
    .SETTLE (SETTLE)
  ) u_lock_supervisor (
    .clk      (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .run_en   (run_en)
  );

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
    end else begin
      h_cnt_d = h_cnt_q + coord_t'(1);
    end
  end

  // v_cnt only moves on the h wrap, so vsync is line-aligned for free.
  always_comb begin
    de_d          = run_en && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hsync_d       = (run_en && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d       = (run_en && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
    x_d           = run_en ? h_cnt_q : '0;
    y_d           = run_en ? v_cnt_q : '0;
    line_start_d  = run_en && (h_cnt_q == '0);
    frame_start_d = run_en && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.frame_start = frame_start_q;
  assign vid.line_start  = line_start_q;
  assign vid.running     = run_en;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: two generators (720p-wide short frame, tiny inverted raster)
// with per-line and per-frame expectations checked by a free-running monitor.
module tb_video_timing_gen;

  typedef struct {
    int len;
    int de_cnt;
    int de_first;
    int hs_cnt;
    int hs_first;
    int vs_act;
    int vs_chg;
    int y;
    int fs;
  } line_t;

  logic clk = 1'b0;
  logic reset;
  logic lock_a;
  logic lock_b;

  int total = 0;
  int bad   = 0;

  line_t exp_line_a[$];
  line_t exp_line_b[$];
  int    exp_frame_a[$];
  int    exp_frame_b[$];

  always #5 clk = ~clk;

  video_timing_gen_if vid_a();
  video_timing_gen_if vid_b();

  video_timing_gen #(
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .SETTLE (4)
  ) dut_a (
    .clk (clk), .reset (reset), .pll_lock (lock_a), .vid (vid_a)
  );

  video_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b0), .SETTLE (2)
  ) dut_b (
    .clk (clk), .reset (reset), .pll_lock (lock_b), .vid (vid_b)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic line_t exp_line(input int len, input int de_len, input int hs_start,
                                     input int hs_len, input int y);
    line_t e;
    e.len      = len;
    e.de_cnt   = (y < 4) ? de_len : 0;
    e.de_first = (y < 4) ? 0 : -1;
    e.hs_cnt   = hs_len;
    e.hs_first = hs_start;
    e.vs_act   = (y == 5) ? 1 : 0;
    e.vs_chg   = 0;
    e.y        = y;
    e.fs       = (y == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic compare_line(input string tag, input line_t a, input line_t e);
    check($sformatf("%s_y%0d_len", tag, e.y), a.len, e.len);
    check($sformatf("%s_y%0d_de_cnt", tag, e.y), a.de_cnt, e.de_cnt);
    check($sformatf("%s_y%0d_de_first", tag, e.y), a.de_first, e.de_first);
    check($sformatf("%s_y%0d_hs_cnt", tag, e.y), a.hs_cnt, e.hs_cnt);
    check($sformatf("%s_y%0d_hs_first", tag, e.y), a.hs_first, e.hs_first);
    check($sformatf("%s_y%0d_vs_act", tag, e.y), a.vs_act, e.vs_act);
    check($sformatf("%s_y%0d_vs_chg", tag, e.y), a.vs_chg, e.vs_chg);
    check($sformatf("%s_y%0d_y", tag, e.y), a.y, e.y);
    check($sformatf("%s_y%0d_fs", tag, e.y), a.fs, e.fs);
  endtask

  // Monitor: measures each completed line and frame period, pops expectations when present.
  line_t cur[2];
  bit    in_line[2];
  bit    have_fs[2];
  int    last_fs[2];
  bit    s_run[2], s_ls[2], s_fs[2], s_de[2], s_hs[2], s_vs[2];
  int    s_y[2];
  int    cyc = 0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_line[d] = 0;
      have_fs[d] = 0;
      last_fs[d] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      s_run[0] = vid_a.running;      s_run[1] = vid_b.running;
      s_ls[0]  = vid_a.line_start;   s_ls[1]  = vid_b.line_start;
      s_fs[0]  = vid_a.frame_start;  s_fs[1]  = vid_b.frame_start;
      s_de[0]  = vid_a.de;           s_de[1]  = vid_b.de;
      s_hs[0]  = (vid_a.hsync == 1'b1); s_hs[1] = (vid_b.hsync == 1'b0);
      s_vs[0]  = (vid_a.vsync == 1'b1); s_vs[1] = (vid_b.vsync == 1'b0);
      s_y[0]   = int'(vid_a.y);      s_y[1]   = int'(vid_b.y);
      for (int d = 0; d < 2; d++) begin
        if (!s_run[d]) begin
          in_line[d] = 0;
          have_fs[d] = 0;
        end else begin
          if (s_fs[d]) begin
            if (have_fs[d]) begin
              if (d == 0 && exp_frame_a.size() > 0)
                check("a_frame_period", cyc - last_fs[d], exp_frame_a.pop_front());
              if (d == 1 && exp_frame_b.size() > 0)
                check("b_frame_period", cyc - last_fs[d], exp_frame_b.pop_front());
            end
            last_fs[d] = cyc;
            have_fs[d] = 1;
          end
          if (s_ls[d]) begin
            if (in_line[d]) begin
              if (d == 0 && exp_line_a.size() > 0) compare_line("a", cur[d], exp_line_a.pop_front());
              if (d == 1 && exp_line_b.size() > 0) compare_line("b", cur[d], exp_line_b.pop_front());
            end
            in_line[d]       = 1;
            cur[d].len       = 0;
            cur[d].de_cnt    = 0;
            cur[d].de_first  = -1;
            cur[d].hs_cnt    = 0;
            cur[d].hs_first  = -1;
            cur[d].vs_act    = s_vs[d] ? 1 : 0;
            cur[d].vs_chg    = 0;
            cur[d].y         = s_y[d];
            cur[d].fs        = s_fs[d] ? 1 : 0;
          end
          if (in_line[d]) begin
            if (s_de[d]) begin
              if (cur[d].de_first < 0) cur[d].de_first = cur[d].len;
              cur[d].de_cnt++;
            end
            if (s_hs[d]) begin
              if (cur[d].hs_first < 0) cur[d].hs_first = cur[d].len;
              cur[d].hs_cnt++;
            end
            if ((s_vs[d] ? 1 : 0) != cur[d].vs_act) cur[d].vs_chg = 1;
            cur[d].len++;
          end
        end
      end
    end
  end

  task automatic wait_run_a(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (vid_a.running) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic wait_xy_a(input int xx, input int yy, input int budget, output int found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (vid_a.running && int'(vid_a.x) == xx && int'(vid_a.y) == yy) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_line_a.size() == 0 && exp_line_b.size() == 0 &&
          exp_frame_a.size() == 0 && exp_frame_b.size() == 0) break;
      @(negedge clk);
    end
    check("sb_lines_a_left", exp_line_a.size(), 0);
    check("sb_lines_b_left", exp_line_b.size(), 0);
    check("sb_frames_a_left", exp_frame_a.size(), 0);
    check("sb_frames_b_left", exp_frame_b.size(), 0);
  endtask

  task automatic check_first_pixel_a(input string tag);
    check({tag, "_fs"}, vid_a.frame_start, 1);
    check({tag, "_ls"}, vid_a.line_start, 1);
    check({tag, "_de"}, vid_a.de, 1);
    check({tag, "_x"}, int'(vid_a.x), 0);
    check({tag, "_y"}, int'(vid_a.y), 0);
  endtask

  task automatic applyStimulus();
    int lat_a, lat_b, found;
    reset  = 1'b1;
    lock_a = 1'b0;
    lock_b = 1'b0;
    #1;
    check("rst_a_hsync", vid_a.hsync, 0);
    check("rst_a_vsync", vid_a.vsync, 0);
    check("rst_b_hsync", vid_b.hsync, 1);
    check("rst_b_vsync", vid_b.vsync, 1);
    check("rst_a_de", vid_a.de, 0);
    check("rst_a_running", vid_a.running, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("nolock_a_running", vid_a.running, 0);
    check("nolock_a_fs", vid_a.frame_start, 0);
    check("nolock_b_hsync", vid_b.hsync, 1);

    for (int k = 0; k < 14; k++) exp_line_b.push_back(exp_line(14, 8, 10, 2, k % 7));
    exp_frame_b.push_back(98);
    exp_frame_b.push_back(98);

    lock_a = 1'b1;
    lock_b = 1'b1;
    lat_a  = -1;
    lat_b  = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (lat_b < 0 && vid_b.running) lat_b = n;
      if (vid_a.running) begin
        lat_a = n;
        break;
      end
    end
    check("a_lock_latency", lat_a, 7);
    check("b_lock_latency", lat_b, 5);
    @(negedge clk);
    check_first_pixel_a("a_first");

    for (int k = 0; k < 14; k++) exp_line_a.push_back(exp_line(1650, 1280, 1390, 40, k % 7));
    exp_frame_a.push_back(11550);
    exp_frame_a.push_back(11550);
    wait_drain(30000);

    lock_b = 1'b0;
    repeat (3) @(negedge clk);
    check("b_unlock_hsync_idle", vid_b.hsync, 1);
    check("b_unlock_vsync_idle", vid_b.vsync, 1);
    check("b_unlock_running", vid_b.running, 0);

    wait_xy_a(600, 3, 15000, found);
    check("a_reach_600_3", found, 1);
    lock_a = 1'b0;
    repeat (2) @(negedge clk);
    check("a_unlock_running", vid_a.running, 0);
    @(negedge clk);
    check("a_unlock_de", vid_a.de, 0);
    check("a_unlock_x", int'(vid_a.x), 0);
    check("a_unlock_y", int'(vid_a.y), 0);
    check("a_unlock_hsync", vid_a.hsync, 0);
    check("a_unlock_vsync", vid_a.vsync, 0);
    check("a_unlock_ls", vid_a.line_start, 0);

    lock_a = 1'b1;
    wait_run_a(40, lat_a);
    check("a_relock_latency", lat_a, 7);
    @(negedge clk);
    check_first_pixel_a("a_relock_first");
    for (int k = 0; k < 7; k++) exp_line_a.push_back(exp_line(1650, 1280, 1390, 40, k));
    exp_frame_a.push_back(11550);
    wait_drain(15000);

    wait_xy_a(100, 1, 15000, found);
    check("a_reach_100_1", found, 1);
    check("a_pre_reset_de", vid_a.de, 1);
    #1 reset = 1'b1;
    #1;
    check("a_async_rst_de", vid_a.de, 0);
    check("a_async_rst_x", int'(vid_a.x), 0);
    check("a_async_rst_y", int'(vid_a.y), 0);
    check("a_async_rst_running", vid_a.running, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_run_a(40, lat_a);
    check("a_post_reset_latency", lat_a, 7);
    @(negedge clk);
    check_first_pixel_a("a_post_reset_first");

    wait_xy_a(1400, 5, 15000, found);
    check("a_reach_1400_5", found, 1);
    check("a_pre_reset_hsync", vid_a.hsync, 1);
    check("a_pre_reset_vsync", vid_a.vsync, 1);
    #1 reset = 1'b1;
    #1;
    check("a_async_rst_hsync", vid_a.hsync, 0);
    check("a_async_rst_vsync", vid_a.vsync, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
